// File: rtl/debug_run_ctrl.sv
// CPU run controller: gates the CPU clock enable for halt, free run, debounced single step and counted burst.
// cpu_en is combinational from registered state; step press to pulse takes 2 + DB_CYCLES + 1 clocks.
module debug_run_ctrl #(
  parameter int DB_CYCLES = 200000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run_sw,
  input  logic        step_btn,
  input  logic        cnt_load,
  input  logic [15:0] cnt_val,
  input  logic        halt_req,
  input  logic        bp_en,
  input  logic [31:0] bp_addr,
  input  logic [31:0] pc,
  output logic        cpu_en,
  output logic [1:0]  state,
  output logic        bp_hit,
  output logic [15:0] burst_left,
  output logic [31:0] step_cnt
);

  localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    STEP  = 2'b10,
    BURST = 2'b11
  } state_t;

  state_t        st;
  logic          sync1, sync2;
  logic          db_level, db_prev;
  logic [CW-1:0] db_cnt;
  logic          bp_skip;
  logic          step_edge;
  logic          bp_raw, bp_match, bp_set;

  assign state     = st;
  assign step_edge = db_level & ~db_prev;
  assign bp_raw    = bp_en && (pc == bp_addr);
  // The skip lets a resumed run execute the instruction it previously stopped on.
  assign bp_match  = bp_raw & ~bp_skip;
  assign bp_set    = ~halt_req & (((st == RUN) & bp_match) | ((st == BURST) & bp_raw));

  always_comb begin
    cpu_en = 1'b0;
    unique case (st)
      IDLE:    cpu_en = 1'b0;
      RUN:     cpu_en = ~bp_match & ~halt_req;
      STEP:    cpu_en = ~halt_req;
      BURST:   cpu_en = ~bp_raw & ~halt_req;
      default: cpu_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      db_level <= 1'b0;
      db_prev  <= 1'b0;
      db_cnt   <= '0;
    end else begin
      sync1   <= step_btn;
      sync2   <= sync1;
      db_prev <= db_level;
      if (sync2 == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_level <= sync2;
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st         <= IDLE;
      bp_skip    <= 1'b0;
      bp_hit     <= 1'b0;
      burst_left <= '0;
      step_cnt   <= '0;
    end else begin
      step_cnt <= step_cnt + {31'b0, cpu_en};
      if (bp_set)
        bp_hit <= 1'b1;
      else if (!run_sw)
        bp_hit <= 1'b0;

      unique case (st)
        IDLE: begin
          if (!halt_req) begin
            if (run_sw && !bp_hit) begin
              st      <= RUN;
              bp_skip <= 1'b1;
            end else if (cnt_load && (cnt_val != 16'd0)) begin
              st         <= BURST;
              burst_left <= cnt_val;
            end else if (step_edge) begin
              st <= STEP;
            end
          end
        end
        RUN: begin
          bp_skip <= 1'b0;
          if (halt_req || bp_match || !run_sw)
            st <= IDLE;
        end
        STEP: st <= IDLE;
        BURST: begin
          if (halt_req || bp_raw) begin
            st         <= IDLE;
            burst_left <= '0;
          end else begin
            burst_left <= burst_left - 16'd1;
            if (burst_left == 16'd1)
              st <= IDLE;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_run_ctrl.sv
// Directed bench for debug_run_ctrl with a short debounce window.
module tb_debug_run_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        run_sw = 1'b0;
  logic        step_btn = 1'b0;
  logic        cnt_load = 1'b0;
  logic [15:0] cnt_val = '0;
  logic        halt_req = 1'b0;
  logic        bp_en = 1'b0;
  logic [31:0] bp_addr = '0;
  logic [31:0] pc = '0;
  logic        cpu_en;
  logic [1:0]  state;
  logic        bp_hit;
  logic [15:0] burst_left;
  logic [31:0] step_cnt;

  int checks = 0;
  int failures = 0;

  debug_run_ctrl #(.DB_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .run_sw(run_sw), .step_btn(step_btn),
    .cnt_load(cnt_load), .cnt_val(cnt_val), .halt_req(halt_req),
    .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc), .cpu_en(cpu_en),
    .state(state), .bp_hit(bp_hit), .burst_left(burst_left), .step_cnt(step_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    logic stray;
    cyc(2);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_cpu_en", 32'(cpu_en), 32'd0);
    chk("rst_bp_hit", 32'(bp_hit), 32'd0);
    chk("rst_burst_left", 32'(burst_left), 32'd0);
    chk("rst_step_cnt", step_cnt, 32'd0);
    rst = 1'b1;
    cyc(2);

    // 3-clock glitch must not get through the debouncer
    step_btn = 1'b1;
    cyc(3);
    step_btn = 1'b0;
    stray = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      if (cpu_en !== 1'b0) stray = 1'b1;
    end
    chk("glitch_no_en", 32'(stray), 32'd0);
    chk("glitch_cnt", step_cnt, 32'd0);

    // clean press: single pulse 7 clocks after the press
    step_btn = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      cyc(1);
      #1;
      chk($sformatf("step1_en_%0d", i), 32'(cpu_en), (i == 7) ? 32'd1 : 32'd0);
    end
    step_btn = 1'b0;
    cyc(10);
    chk("step1_cnt", step_cnt, 32'd1);
    step_btn = 1'b1;
    cyc(10);
    step_btn = 1'b0;
    cyc(10);
    chk("step2_cnt", step_cnt, 32'd2);
    chk("step2_state", 32'(state), 32'd0);

    // burst of 5
    cnt_val = 16'd5;
    cnt_load = 1'b1;
    cyc(1);
    cnt_load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("burst_en_%0d", i), 32'(cpu_en), 32'd1);
      chk($sformatf("burst_left_%0d", i), 32'(burst_left), 32'(5 - i));
      chk($sformatf("burst_state_%0d", i), 32'(state), 32'd3);
      cyc(1);
    end
    #1;
    chk("burst_end_left", 32'(burst_left), 32'd0);
    chk("burst_end_state", 32'(state), 32'd0);
    chk("burst_end_en", 32'(cpu_en), 32'd0);
    chk("burst_end_cnt", step_cnt, 32'd7);

    // zero-length burst is a no-op
    cnt_val = 16'd0;
    cnt_load = 1'b1;
    cyc(1);
    cnt_load = 1'b0;
    #1;
    chk("burst0_state", 32'(state), 32'd0);
    chk("burst0_en", 32'(cpu_en), 32'd0);
    cyc(1);
    chk("burst0_cnt", step_cnt, 32'd7);

    // halt after two enabled cycles
    cnt_val = 16'd5;
    cnt_load = 1'b1;
    cyc(1);
    cnt_load = 1'b0;
    cyc(2);
    halt_req = 1'b1;
    #1;
    chk("halt_same_cycle_en", 32'(cpu_en), 32'd0);
    cyc(1);
    chk("halt_state", 32'(state), 32'd0);
    chk("halt_left", 32'(burst_left), 32'd0);
    chk("halt_cnt", step_cnt, 32'd9);
    halt_req = 1'b0;
    cyc(1);

    // breakpoint at 0xC under free run
    bp_en = 1'b1;
    bp_addr = 32'h0000_000C;
    pc = 32'h0;
    run_sw = 1'b1;
    cyc(1);
    #1;
    chk("bp_en_pc0", 32'(cpu_en), 32'd1);
    cyc(1); pc = 32'h4; #1;
    chk("bp_en_pc4", 32'(cpu_en), 32'd1);
    cyc(1); pc = 32'h8; #1;
    chk("bp_en_pc8", 32'(cpu_en), 32'd1);
    cyc(1); pc = 32'hC; #1;
    chk("bp_en_pcC", 32'(cpu_en), 32'd0);
    cyc(1);
    chk("bp_hit_set", 32'(bp_hit), 32'd1);
    chk("bp_state", 32'(state), 32'd0);
    chk("bp_cnt", step_cnt, 32'd12);
    cyc(1);
    chk("bp_hold_idle", 32'(state), 32'd0);
    run_sw = 1'b0;
    cyc(1);
    chk("bp_hit_clr", 32'(bp_hit), 32'd0);
    run_sw = 1'b1;
    cyc(1);
    #1;
    chk("resume_state", 32'(state), 32'd1);
    chk("resume_en_pcC", 32'(cpu_en), 32'd1);
    cyc(1);
    pc = 32'h10;
    run_sw = 1'b0;
    cyc(1);
    chk("resume_stop_state", 32'(state), 32'd0);
    chk("resume_cnt", step_cnt, 32'd14);
    bp_en = 1'b0;

    // run_sw and step_edge together: run wins, step dropped
    step_btn = 1'b1;
    cyc(6);
    run_sw = 1'b1;
    cyc(1);
    chk("simul_run", 32'(state), 32'd1);
    cyc(2);
    run_sw = 1'b0;
    cyc(1);
    chk("simul_idle", 32'(state), 32'd0);
    stray = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      if (state !== 2'b00 || cpu_en !== 1'b0) stray = 1'b1;
    end
    chk("simul_no_step", 32'(stray), 32'd0);
    chk("simul_cnt", step_cnt, 32'd17);
    step_btn = 1'b0;
    cyc(10);

    // counter wrap
    force dut.step_cnt = 32'hFFFF_FFFE;
    cyc(1);
    release dut.step_cnt;
    #1;
    chk("wrap_preload", step_cnt, 32'hFFFF_FFFE);
    run_sw = 1'b1;
    cyc(3);
    run_sw = 1'b0;
    cyc(1);
    chk("wrap_cnt", step_cnt, 32'h0000_0001);
    chk("wrap_state", 32'(state), 32'd0);

    // asynchronous reset in the middle of a run
    run_sw = 1'b1;
    cyc(2);
    #2;
    chk("pre_rst_en", 32'(cpu_en), 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_en", 32'(cpu_en), 32'd0);
    chk("mid_rst_state", 32'(state), 32'd0);
    chk("mid_rst_cnt", step_cnt, 32'd0);
    chk("mid_rst_bp_hit", 32'(bp_hit), 32'd0);
    chk("mid_rst_left", 32'(burst_left), 32'd0);
    run_sw = 1'b0;
    cyc(1);
    rst = 1'b1;
    cyc(2);
    chk("post_rst_en", 32'(cpu_en), 32'd0);
    chk("post_rst_state", 32'(state), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
